// File: rtl/encoder_onehot_stream_pkg.sv
// Shared types for the one-hot encoder stream: handshake state, result payload, counter width.
// The result payload depends on the index width, so it is provided as a width-taking macro.
`ifndef ENCODER_ONEHOT_STREAM_PKG_SV
`define ENCODER_ONEHOT_STREAM_PKG_SV

`define ENCODER_RESULT_T(WIDTH) struct packed { logic [(WIDTH)-1:0] idx; logic err; logic zero; }

package encoder_pkg;

  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned N_MIN     = 2;
  localparam int unsigned N_MAX     = 256;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Index width for an n-bit request vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < N_MIN) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/encoder_onehot_stream_if.sv
// Valid/ready request-in, index-out bundle of the one-hot encoder stream.
// slave is the encoder side; master is the producer/consumer side.
interface encoder_onehot_stream_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
);

  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_idx;
  logic         out_err;
  logic         out_zero;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_idx, out_err, out_zero, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_idx, out_err, out_zero, out_valid
  );

endinterface

// File: rtl/encoder_onehot_stream_prio_core.sv
// Combinational N-to-W priority encoder with zero and not-one-hot flags.
module encoder_prio_core
  import encoder_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter bit          PRIO_MSB = 1'b0,
  parameter int unsigned W        = idx_width(N)
) (
  input  logic [N-1:0] data,
  output logic [W-1:0] idx_c,
  output logic         err_c,
  output logic         zero_c
);

  logic        seen;
  logic        multi;
  int unsigned pos;

  // Scan in priority order; the first set bit found is the winner.
  always_comb begin
    idx_c = '0;
    seen  = 1'b0;
    multi = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = PRIO_MSB ? (N - 1 - i) : i;
      if (data[pos]) begin
        if (seen) begin
          multi = 1'b1;
        end else begin
          idx_c = W'(pos);
        end
        seen = 1'b1;
      end
    end
    zero_c = !seen;
    err_c  = !seen || multi;
  end

endmodule

// File: rtl/encoder_onehot_stream.sv
// Registered one-hot encoder with a 2-entry skid buffer on the output side.
// Optional ENCODER_STREAM_ERR_CNT_EN adds a saturating count of accepted non-one-hot beats.
module encoder_onehot_stream
  import encoder_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter bit          PRIO_MSB = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ENCODER_STREAM_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  encoder_onehot_stream_if.slave bus
);

  localparam int unsigned W = $clog2(N);

  typedef `ENCODER_RESULT_T(W) result_t;

  state_t  state_q, state_d;
  result_t main_q, skid_q, enc;
  logic    in_ready_q, out_valid_q;
  logic    accept, consume;
  logic    ld_main, ld_skid, mv_skid;

  logic [W-1:0] enc_idx;
  logic         enc_err;
  logic         enc_zero;

  encoder_prio_core #(
    .N        (N),
    .PRIO_MSB (PRIO_MSB),
    .W        (W)
  ) u_core (
    .data   (bus.in_data),
    .idx_c  (enc_idx),
    .err_c  (enc_err),
    .zero_c (enc_zero)
  );

  assign enc     = {enc_idx, enc_err, enc_zero};
  assign accept  = bus.in_valid && in_ready_q;
  assign consume = out_valid_q && bus.out_ready;

  // Next-state and register-load decisions.
  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          ld_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && !consume) begin
          state_d = TWO;
          ld_skid = 1'b1;
        end else if (consume && !accept) begin
          state_d = EMPTY;
        end else if (accept && consume) begin
          ld_main = 1'b1;
        end
      end
      TWO: begin
        if (consume) begin
          state_d = ONE;
          mv_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and handshake flags; in_ready is a pure register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Main register feeds the outputs; skid catches a beat taken during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main) begin
        main_q <= enc;
      end else if (mv_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= enc;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = main_q.idx;
  assign bus.out_err   = main_q.err;
  assign bus.out_zero  = main_q.zero;

`ifdef ENCODER_STREAM_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Counted at accept time, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (accept && enc_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_encoder_onehot_stream.sv
// Self-checking bench: four encoder configurations share one handshake and are
// compared against a queue-based reference model plus a directed vector table.
module tb_encoder_onehot_stream;

  typedef struct {
    int idx;
    bit err;
    bit zero;
  } res_t;

  typedef struct {
    logic [15:0] d;
    int          idx_lsb;
    int          idx_msb;
    bit          err;
    bit          zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        vin;
  logic        ordy;

  int vectors     = 0;
  int miscompares = 0;

  res_t        q [4][$];
  int unsigned mcnt [4];

  always #5 clk = ~clk;

  encoder_onehot_stream_if #(.N(8),  .W(3)) if8  ();
  encoder_onehot_stream_if #(.N(8),  .W(3)) if8m ();
  encoder_onehot_stream_if #(.N(5),  .W(3)) if5  ();
  encoder_onehot_stream_if #(.N(16), .W(4)) if16 ();

  assign if8.in_data   = din[7:0];
  assign if8.in_valid  = vin;
  assign if8.out_ready = ordy;
  assign if8m.in_data   = din[7:0];
  assign if8m.in_valid  = vin;
  assign if8m.out_ready = ordy;
  assign if5.in_data   = din[4:0];
  assign if5.in_valid  = vin;
  assign if5.out_ready = ordy;
  assign if16.in_data   = din;
  assign if16.in_valid  = vin;
  assign if16.out_ready = ordy;

`ifdef ENCODER_STREAM_ERR_CNT_EN
  logic [15:0] cnt [4];
`endif

  encoder_onehot_stream #(.N(8), .PRIO_MSB(1'b0)) u8 (
    .clk(clk), .rst(rst),
`ifdef ENCODER_STREAM_ERR_CNT_EN
    .err_cnt(cnt[0]),
`endif
    .bus(if8.slave));

  encoder_onehot_stream #(.N(8), .PRIO_MSB(1'b1)) u8m (
    .clk(clk), .rst(rst),
`ifdef ENCODER_STREAM_ERR_CNT_EN
    .err_cnt(cnt[1]),
`endif
    .bus(if8m.slave));

  encoder_onehot_stream #(.N(5), .PRIO_MSB(1'b0)) u5 (
    .clk(clk), .rst(rst),
`ifdef ENCODER_STREAM_ERR_CNT_EN
    .err_cnt(cnt[2]),
`endif
    .bus(if5.slave));

  encoder_onehot_stream #(.N(16), .PRIO_MSB(1'b0)) u16 (
    .clk(clk), .rst(rst),
`ifdef ENCODER_STREAM_ERR_CNT_EN
    .err_cnt(cnt[3]),
`endif
    .bus(if16.slave));

  function automatic int n_of(input int k);
    case (k)
      2:       return 5;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  // Reference: count set bits; lowest set bit wins, or highest when msb is set.
  function automatic res_t ref_enc(input logic [15:0] d, input int n, input bit msb);
    res_t r;
    int   ones = 0;
    r.idx = 0;
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        ones++;
        if (msb || ones == 1) r.idx = i;
      end
    end
    r.err  = (ones != 1);
    r.zero = (ones == 0);
    return r;
  endfunction

  task automatic chk(input int k, input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL u%0d.%s: got %0d expected %0d at %0t", k, name, act, exp, $time);
    end
  endtask

  task automatic get_out(input int k, output bit ov, output int idx, output bit err,
                         output bit zero, output bit ir);
    case (k)
      0: begin ov = if8.out_valid;  idx = int'(if8.out_idx);  err = if8.out_err;  zero = if8.out_zero;  ir = if8.in_ready;  end
      1: begin ov = if8m.out_valid; idx = int'(if8m.out_idx); err = if8m.out_err; zero = if8m.out_zero; ir = if8m.in_ready; end
      2: begin ov = if5.out_valid;  idx = int'(if5.out_idx);  err = if5.out_err;  zero = if5.out_zero;  ir = if5.in_ready;  end
      default: begin ov = if16.out_valid; idx = int'(if16.out_idx); err = if16.out_err; zero = if16.out_zero; ir = if16.in_ready; end
    endcase
  endtask

  // One clock: drive at negedge, check all DUTs against the model, advance the model.
  task automatic cycle(input logic [15:0] d, input bit v, input bit r);
    bit ov, err, zero, ir, m_ir, m_ov;
    int idx;
    din = d; vin = v; ordy = r;
    #1;
    for (int k = 0; k < 4; k++) begin
      get_out(k, ov, idx, err, zero, ir);
      m_ir = (q[k].size() < 2);
      m_ov = (q[k].size() > 0);
      chk(k, "in_ready", int'(ir), int'(m_ir));
      chk(k, "out_valid", int'(ov), int'(m_ov));
      if (m_ov) begin
        chk(k, "out_idx", idx, q[k][0].idx);
        chk(k, "out_err", int'(err), int'(q[k][0].err));
        chk(k, "out_zero", int'(zero), int'(q[k][0].zero));
      end
`ifdef ENCODER_STREAM_ERR_CNT_EN
      chk(k, "err_cnt", int'(cnt[k]), int'(mcnt[k]));
`endif
      if (m_ov && r) void'(q[k].pop_front());
      if (m_ir && v) begin
        res_t e = ref_enc(d, n_of(k), (k == 1));
        q[k].push_back(e);
        if (e.err && mcnt[k] < 32'hFFFF) mcnt[k]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; vin = 1'b0; ordy = 1'b0; din = '0;
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      mcnt[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [15:0] rd;

    rst = 1'b1; din = '0; vin = 1'b0; ordy = 1'b0;
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk(0, "rst_out_valid", int'(if8.out_valid), 0);
    chk(0, "rst_in_ready",  int'(if8.in_ready), 1);
    chk(0, "rst_out_idx",   int'(if8.out_idx), 0);
    chk(0, "rst_out_err",   int'(if8.out_err), 0);
    chk(0, "rst_out_zero",  int'(if8.out_zero), 0);
    chk(3, "rst_out_valid", int'(if16.out_valid), 0);
`ifdef ENCODER_STREAM_ERR_CNT_EN
    chk(0, "rst_err_cnt",   int'(cnt[0]), 0);
`endif
    rst = 1'b0;

    // Directed table: one-hot sweep then zero / multi-hot patterns, back to back.
    for (int i = 0; i < 8; i++)
      tbl.push_back('{d: 16'(1 << i), idx_lsb: i, idx_msb: i, err: 1'b0, zero: 1'b0});
    tbl.push_back('{d: 16'h0000, idx_lsb: 0, idx_msb: 0, err: 1'b1, zero: 1'b1});
    tbl.push_back('{d: 16'h0028, idx_lsb: 3, idx_msb: 5, err: 1'b1, zero: 1'b0});
    tbl.push_back('{d: 16'h00FF, idx_lsb: 0, idx_msb: 7, err: 1'b1, zero: 1'b0});
    tbl.push_back('{d: 16'h0081, idx_lsb: 0, idx_msb: 7, err: 1'b1, zero: 1'b0});

    foreach (tbl[i]) begin
      cycle(tbl[i].d, 1'b1, 1'b1);
      chk(0, "tbl_valid", int'(if8.out_valid), 1);
      chk(0, "tbl_in_ready", int'(if8.in_ready), 1);
      chk(0, "tbl_idx", int'(if8.out_idx), tbl[i].idx_lsb);
      chk(0, "tbl_err", int'(if8.out_err), int'(tbl[i].err));
      chk(0, "tbl_zero", int'(if8.out_zero), int'(tbl[i].zero));
      chk(1, "tbl_idx_msb", int'(if8m.out_idx), tbl[i].idx_msb);
      chk(1, "tbl_err_msb", int'(if8m.out_err), int'(tbl[i].err));
      if (tbl[i].d == 16'h0010) begin
        chk(2, "n5_idx", int'(if5.out_idx), 4);
        chk(2, "n5_err", int'(if5.out_err), 0);
      end
    end
    cycle(16'h0000, 1'b0, 1'b1);
    chk(0, "tbl_drained", int'(if8.out_valid), 0);

    // Stall: continuous input with out_ready low for 3 cycles.
    cycle(16'h0400, 1'b1, 1'b0);
    cycle(16'h2000, 1'b1, 1'b0);
    chk(3, "stall_in_ready", int'(if16.in_ready), 0);
    chk(3, "stall_idx", int'(if16.out_idx), 10);
    cycle(16'h8000, 1'b1, 1'b0);
    chk(3, "stall_idx_hold", int'(if16.out_idx), 10);
    chk(3, "stall_valid_hold", int'(if16.out_valid), 1);
    cycle(16'h8000, 1'b1, 1'b1);
    chk(3, "release_idx1", int'(if16.out_idx), 13);
    chk(3, "release_in_ready", int'(if16.in_ready), 1);
    cycle(16'h8000, 1'b1, 1'b1);
    chk(3, "release_idx2", int'(if16.out_idx), 15);
    cycle(16'h0000, 1'b0, 1'b1);
    chk(3, "release_drained", int'(if16.out_valid), 0);

    // Reset while two beats are held.
    cycle(16'h0001, 1'b1, 1'b0);
    cycle(16'h0002, 1'b1, 1'b0);
    chk(3, "pre_rst_in_ready", int'(if16.in_ready), 0);
    vin = 1'b0;
    rst = 1'b1;
    #1;
    chk(3, "mid_rst_out_valid", int'(if16.out_valid), 0);
    chk(3, "mid_rst_in_ready", int'(if16.in_ready), 1);
    chk(0, "mid_rst_out_idx", int'(if8.out_idx), 0);
    do_reset();
    cycle(16'h0000, 1'b0, 1'b1);
    chk(3, "post_rst_empty", int'(if16.out_valid), 0);

    // Randomised traffic checked against the model.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = 16'(1 << $urandom_range(0, 15));
        1:       rd = 16'h0000;
        default: rd = 16'($urandom);
      endcase
      cycle(rd, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    repeat (4) cycle(16'h0000, 1'b0, 1'b1);

`ifdef ENCODER_STREAM_ERR_CNT_EN
    // Error counter: 5 invalid among 10, then saturation.
    do_reset();
    for (int i = 0; i < 10; i++)
      cycle(((i % 2) != 0) ? 16'h0003 : 16'h0001, 1'b1, 1'b1);
    cycle(16'h0000, 1'b0, 1'b1);
    chk(0, "err_cnt_5", int'(cnt[0]), 5);
    repeat (65540) cycle(16'h0000, 1'b1, 1'b1);
    cycle(16'h0000, 1'b0, 1'b1);
    chk(0, "err_cnt_sat", int'(cnt[0]), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/encoder_onehot_stream.md
# encoder_onehot_stream

Parametrised, registered successor to the team's fixed 8-to-3 one-hot encoder. Accepts an N-bit request vector per valid/ready beat, encodes it to a $clog2(N)-bit index with selectable LSB/MSB priority, flags non-one-hot inputs, and delivers results through a 2-entry skid buffer. It sits between arbitration/request logic and downstream index consumers where full throughput and a registered `in_ready` are required.

## Interface
- `N`, 8, input vector width; legal range 2..256
- `W`, $clog2(N), output index width; derived, not overridden
- `PRIO_MSB`, 0, 0: lowest set bit wins; 1: highest set bit wins
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `in_data`  input  N  request vector
- `in_valid`  input  1  `in_data` valid
- `in_ready`  output  1  block accepts a beat this cycle; registered
- `out_idx`  output  W  encoded index
- `out_err`  output  1  beat was not one-hot (zero or multi-hot)
- `out_zero`  output  1  beat had no bit set
- `out_valid`  output  1  `out_idx`/`out_err`/`out_zero` valid
- `out_ready`  input  1  downstream accepts
- `err_cnt`  output  16  saturating invalid-beat count; present only with `ENCODER_STREAM_ERR_CNT_EN`

## Operation
- Encode: `out_idx` = index of winning set bit per `PRIO_MSB`; `out_err` = popcount(`in_data`) != 1; `out_zero` = (`in_data` == 0). Zero input: `out_idx` = 0, `out_err` = 1, `out_zero` = 1. Multi-hot: index of priority winner, `out_err` = 1, `out_zero` = 0.
- Encoding is computed on the input side; main and skid registers hold encoded results {idx, err, zero}, not raw vectors.
- Accept = `in_valid` && `in_ready`; consume = `out_valid` && `out_ready`.
- States: EMPTY (nothing held), ONE (main reg full), TWO (main and skid full).
  - EMPTY: accept -> ONE, load main.
  - ONE: accept && !consume -> TWO, load skid; consume && !accept -> EMPTY; accept && consume -> ONE, load main with new beat; neither -> ONE.
  - TWO: consume -> ONE, skid moves to main; no accept possible.
- `out_valid` = state != EMPTY. `in_ready` = next-state != TWO, registered.
- Ordering strictly FIFO; no beat dropped or duplicated.
- Outputs of held beats stay stable while `out_valid` && !`out_ready`.

## Timing
- Latency: 1 cycle from accepted beat to `out_valid` when block empty.
- Throughput: 1 beat/cycle sustained while `out_ready` = 1.
- `in_ready` depends on registers only; no combinational path from `out_ready` to `in_ready` or from `in_*` to `out_*`.
- Reset (async assert, sync release in system): state = EMPTY, `in_ready` = 1, `out_valid` = 0, `out_idx` = 0, `out_err` = 0, `out_zero` = 0, `err_cnt` = 0. Reset mid-transfer discards held beats.
- `out_ready` stall of one cycle with continuous input: state goes TWO, `in_ready` low the following cycle.

## Configuration
- `ENCODER_STREAM_ERR_CNT_EN` defined: `err_cnt` port exists; increments by 1 on each accepted beat with `out_err` = 1 (at accept, not consume); saturates at 16'hFFFF; cleared only by `rst`.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `encoder_pkg`: state typedef (EMPTY/ONE/TWO), result struct {idx, err, zero} parametrised by W via typed function/macro, `ERR_CNT_W` = 16.
- Sub-module `encoder_prio_core`: combinational N-to-W priority encoder with err/zero outputs, `N`/`PRIO_MSB` parameters; top holds handshake, skid buffer, counter.

## Test plan
- N=8, PRIO_MSB=0, `out_ready`=1, stream 8'h01,8'h02,...,8'h80 -> `out_idx` 0..7 one cycle later each, `out_err`=0, no bubbles.
- N=8, input 8'h00 -> `out_idx`=0, `out_err`=1, `out_zero`=1; input 8'h28 -> PRIO_MSB=0 gives idx 3, PRIO_MSB=1 gives idx 5, `out_err`=1.
- N=16, continuous input, `out_ready` low 3 cycles -> state TWO, `in_ready`=0 after 2 accepts, outputs stable; release -> FIFO order preserved, no loss.
- `rst` asserted while state TWO -> `out_valid`=0 and `in_ready`=1 immediately, held beats lost.
- With `ENCODER_STREAM_ERR_CNT_EN`: 5 invalid beats among 10 -> `err_cnt`=5; force 65540 invalid beats -> `err_cnt`=16'hFFFF.
- N=5 (non-power-of-two), input 5'b10000 -> `out_idx`=4, W=3.
